// File: rtl/seven_segment_mux.sv
// seven_segment_mux
// Time-multiplexed seven-segment driver for DIGITS hex/BCD digits.
// Each digit owns a slot of SCAN_DIV cycles; the first BLANK_CYCLES of a
// slot are dead time (everything off) to suppress ghosting. Loaded values
// are committed to the display register only at the frame boundary, so a
// frame never mixes old and new digits.
//
// Optional feature macro: SEVSEG_HEX_EN
//   defined   -> codes 10..15 decode to A b C d E F
//   undefined -> codes 10..15 show all segments off (digit_en still scans)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   load       single-cycle strobe, captures digits_in
//   digits_in  digit k at [4k+3:4k], digit 0 least significant
//   lz_blank   leading-zero blanking enable, sampled live
//   segments   bit0=a .. bit6=g, polarity per ACTIVE_LOW
//   digit_en   one-hot digit select while active, polarity per ACTIVE_LOW
//   load_ack   one-cycle pulse when a loaded value is committed
//
// Slot phases:
//   phase  | meaning
//   blank  | p <  BLANK_CYCLES : all digit_en inactive, segments off
//   active | p >= BLANK_CYCLES : digit idx driven unless leading-zero blanked
module seven_segment_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  lz_blank,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  load_ack
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0]    BLANK_THR = (CNT_W + 1)'(SCAN_DIV - BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] EN_OFF    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                : {DIGITS{1'b0}};

    // The prescaler is a down-counter: cnt = SCAN_DIV-1-p, so the slot
    // ends at terminal count zero and the blank phase is the top of the range.
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] display;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;

    logic                slot_end;
    logic                frame_end;
    logic                in_blank;
    logic [3:0]          cur_nib;
    logic [DIGITS-1:0]   blank_mask;
    logic                nz_above;
    logic                cur_blanked;
    logic [6:0]          seg_raw;
    logic [DIGITS-1:0]   en_raw;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
`ifdef SEVSEG_HEX_EN
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
`else
            default: pat = 7'h00;
`endif
        endcase
        return pat;
    endfunction

    assign slot_end  = (cnt == '0);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_blank  = ({1'b0, cnt} >= BLANK_THR);

    always_comb begin
        cur_nib     = 4'h0;
        cur_blanked = 1'b0;
        blank_mask  = '0;
        nz_above    = !lz_blank;
        seg_raw     = 7'h00;
        en_raw      = '0;

        // A digit is blanked while every digit from the top down to it is
        // zero; digit 0 is never included so a value of 0 still shows "0".
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz_above      = nz_above | (display[4*k +: 4] != 4'h0);
            blank_mask[k] = !nz_above;
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib     = display[4*k +: 4];
                cur_blanked = blank_mask[k];
            end
        end

        if (!in_blank && !cur_blanked) begin
            seg_raw = decode(cur_nib);
            for (int k = 0; k < DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    en_raw[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= CNT_TOP;
            idx      <= '0;
            display  <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
            segments <= SEG_OFF;
            digit_en <= EN_OFF;
        end else begin
            cnt <= slot_end ? CNT_TOP : (cnt - CNT_W'(1));
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : (idx + IDX_W'(1));
            end

            if (load) begin
                shadow <= digits_in;
            end

            // A load on the boundary edge itself bypasses the shadow so the
            // freshest value wins.
            load_ack <= 1'b0;
            if (frame_end && (pending || load)) begin
                display  <= load ? digits_in : shadow;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end

            segments <= (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            digit_en <= (ACTIVE_LOW != 0) ? ~en_raw  : en_raw;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

    localparam int DIGITS = 4;
    localparam int SCAN   = 8;
    localparam int BLANK  = 2;

`ifdef SEVSEG_HEX_EN
    localparam logic [6:0] HEX_A_EXP = 7'h08;
`else
    localparam logic [6:0] HEX_A_EXP = 7'h7F;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_blank;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        load_ack;

    int tests_run = 0;
    int fails     = 0;
    int ack_cnt   = 0;
    int a0;

    seven_segment_mux #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
        .lz_blank(lz_blank), .segments(segments), .digit_en(digit_en),
        .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] en;
        logic       ack;
    } exp_t;

    exp_t q[$];

    // Active-high gfedcba patterns.
    function automatic logic [6:0] seg_pat(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
`ifdef SEVSEG_HEX_EN
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            4'hF: return 7'h71;
`endif
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit lz_hidden(input logic [15:0] v, input logic lz, input int d);
        if (!lz || d == 0) return 1'b0;
        for (int k = 3; k >= d; k--) begin
            if (v[4*k +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: cycle count since reset gives slot position directly.
    int unsigned m_n;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;

    always @(posedge clk) begin
        exp_t e;
        int   p;
        int   d;
        logic commit;
        if (reset) begin
            e.seg = 7'h7F; e.en = 4'hF; e.ack = 1'b0;
            m_n = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
        end else begin
            p = int'(m_n % SCAN);
            d = int'((m_n / SCAN) % DIGITS);
            e.seg = 7'h7F;
            e.en  = 4'hF;
            if (p >= BLANK && !lz_hidden(m_disp, lz_blank, d)) begin
                e.seg = ~seg_pat(m_disp[4*d +: 4]);
                e.en  = ~(4'b0001 << d);
            end
            if (load) begin
                m_shadow = digits_in;
                m_pend   = 1'b1;
            end
            commit = (p == SCAN - 1) && (d == DIGITS - 1) && m_pend;
            if (commit) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            e.ack = commit;
            m_n++;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests_run++;
            assert (segments === e.seg) else begin
                fails++;
                $error("FAIL sb_segments t=%0t got %h expected %h", $time, segments, e.seg);
            end
            tests_run++;
            assert (digit_en === e.en) else begin
                fails++;
                $error("FAIL sb_digit_en t=%0t got %h expected %h", $time, digit_en, e.en);
            end
            tests_run++;
            assert (load_ack === e.ack) else begin
                fails++;
                $error("FAIL sb_load_ack t=%0t got %b expected %b", $time, load_ack, e.ack);
            end
        end
    end

    always @(posedge clk) if (load_ack === 1'b1) ack_cnt++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just before edge 1 of a fresh run.
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load      = 1'b1;
        digits_in = v;
        step(1);
        load      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; digits_in = '0; lz_blank = 1'b0;

        // reset release, no load
        step(2);
        chk("rst_seg", 16'(segments), 16'h7F);
        chk("rst_en",  16'(digit_en), 16'hF);
        chk("rst_ack", 16'(load_ack), 16'h0);
        reset = 1'b0;
        a0 = ack_cnt;
        step(2);
        chk("e2_blank_en",  16'(digit_en), 16'hF);
        chk("e2_blank_seg", 16'(segments), 16'h7F);
        step(1);
        chk("e3_d0_en",  16'(digit_en), 16'hE);
        chk("e3_d0_seg", 16'(segments), 16'h40);
        step(8);
        chk("e11_d1_en", 16'(digit_en), 16'hD);
        step(24);
        chk("e35_d0_en", 16'(digit_en), 16'hE);
        chk("noload_acks", 16'(ack_cnt - a0), 16'h0);

        // mid-frame load 0x1234 at edge 10
        do_reset();
        a0 = ack_cnt;
        step(9);
        do_load(16'h1234);
        step(22);
        chk("e32_ack",     16'(load_ack), 16'h1);
        chk("e32_old_seg", 16'(segments), 16'h40);
        chk("e32_old_en",  16'(digit_en), 16'h7);
        step(1);
        chk("e33_ack_low", 16'(load_ack), 16'h0);
        step(2);
        chk("e35_seg4", 16'(segments), 16'h19);
        chk("e35_en0",  16'(digit_en), 16'hE);
        step(24);
        chk("e59_seg1", 16'(segments), 16'h79);
        chk("e59_en3",  16'(digit_en), 16'h7);
        step(2);
        chk("mid_ack_count", 16'(ack_cnt - a0), 16'h1);

        // double load in one frame
        do_reset();
        a0 = ack_cnt;
        step(4);
        do_load(16'h1111);
        step(6);
        do_load(16'h2222);
        step(31);
        chk("dbl_d1_seg", 16'(segments), 16'h24);
        chk("dbl_d1_en",  16'(digit_en), 16'hD);
        step(16);
        chk("dbl_d3_seg", 16'(segments), 16'h24);
        step(2);
        chk("dbl_ack_count", 16'(ack_cnt - a0), 16'h1);

        // leading-zero blanking on 0x0050
        do_reset();
        lz_blank = 1'b1;
        step(2);
        do_load(16'h0050);
        step(33);
        chk("lz_d0_seg", 16'(segments), 16'h40);
        chk("lz_d0_en",  16'(digit_en), 16'hE);
        step(8);
        chk("lz_d1_seg", 16'(segments), 16'h12);
        chk("lz_d1_en",  16'(digit_en), 16'hD);
        step(8);
        chk("lz_d2_seg", 16'(segments), 16'h7F);
        chk("lz_d2_en",  16'(digit_en), 16'hF);
        step(8);
        chk("lz_d3_seg", 16'(segments), 16'h7F);
        chk("lz_d3_en",  16'(digit_en), 16'hF);
        lz_blank = 1'b0;
        step(2);

        // hex code 0xA
        do_reset();
        step(2);
        do_load(16'h000A);
        step(33);
        chk("hex_d0_seg", 16'(segments), 16'(HEX_A_EXP));
        chk("hex_d0_en",  16'(digit_en), 16'hE);
        step(8);
        chk("hex_d1_seg", 16'(segments), 16'h40);

        // reset during an active slot with a load pending
        do_reset();
        a0 = ack_cnt;
        step(2);
        do_load(16'h1234);
        step(17);
        chk("pre_rst_en", 16'(digit_en), 16'hB);
        reset = 1'b1;
        step(1);
        chk("midrst_seg", 16'(segments), 16'h7F);
        chk("midrst_en",  16'(digit_en), 16'hF);
        chk("midrst_ack", 16'(load_ack), 16'h0);
        step(1);
        reset = 1'b0;
        step(3);
        chk("post_d0_seg", 16'(segments), 16'h40);
        step(32);
        chk("post_f2_seg", 16'(segments), 16'h40);
        chk("post_f2_en",  16'(digit_en), 16'hE);
        step(16);
        chk("post_d2_seg", 16'(segments), 16'h40);
        chk("post_ack_count", 16'(ack_cnt - a0), 16'h0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
